neural_layer_stream: RTL and testbench

Streaming multi-neuron post-processor for the matrix multiplier core. It accepts one vector of M weighted sums per `start`, one sum per neuron, over a valid/ready handshake. For each sum it adds a per-neuron bias with saturation and applies one of four run-time-selectable activations. Results are buffered in an output FIFO with backpressure and last-neuron tagging, so the block can feed the next layer or the host readout directly.

---
 rtl/neural_layer_stream_if.sv | 39 +++
 rtl/neural_layer_stream.sv | 232 +++++++++++++++++++++++
 tb/tb_neural_layer_stream.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/neural_layer_stream_if.sv
// ---------------------------------------------------------------------------
// neural_layer_stream_if
//   Handshake bundle for neural_layer_stream: the input stream of weighted
//   sums from the matrix core and the output stream of activated results.
//
//   Signals
//     in_data   : signed weighted sum, one per neuron
//     in_valid  : producer has a sum on in_data
//     in_ready  : layer can accept a sum this cycle
//     out_data  : activated result at the FIFO head
//     out_valid : FIFO holds at least one result
//     out_ready : consumer takes the head result this cycle
//     out_last  : head result belongs to the final neuron of the vector
//
//   Modports
//     master : the environment around the layer (feeds sums, drains results)
//     slave  : the layer itself
// ---------------------------------------------------------------------------
interface neural_layer_stream_if #(
    parameter int ACC_WIDTH = 16
);
    logic signed [ACC_WIDTH-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [ACC_WIDTH-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/neural_layer_stream.sv
// ---------------------------------------------------------------------------
// neural_layer_stream
//   Streaming post-processor for one vector of M weighted sums. Each sum gets
//   its neuron's bias added with saturation (stage 1), then one of four
//   activations (stage 2), and lands in a first-word-fall-through output FIFO
//   tagged with a last flag for neuron M-1.
//
//   Ports
//     clk, rst        : clock, asynchronous active-high reset
//     start           : begin a vector (IDLE only)
//     activation_type : 00 ReLU, 01 leaky ReLU, 10 linear, 11 clip; latched at start
//     bias_in/_wen/_addr : bias memory write port, honoured only in IDLE
//     bus (slave)     : in_data/in_valid/in_ready and
//                       out_data/out_valid/out_ready/out_last streams
//     busy            : high outside IDLE
//     done            : one-cycle pulse after the last result is popped
//     sat_count       : saturation/clamp event counter
//
//   Build option
//     NEURAL_SAT_COUNT_EN : when defined, sat_count counts stage-1 saturations
//                           and clip-mode clamps (sticky at 255); otherwise it
//                           is tied to zero and no counter exists.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | waiting for start; bias writes allowed
//   S_RUN   | accepting sums, neuron_idx counts accepted beats
//   S_DRAIN | all M sums taken; waiting for the last result to pop
//   S_DONE  | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module neural_layer_stream #(
    parameter int M          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH,
    parameter int LEAK_SHIFT = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   activation_type,
    input  logic signed [DATA_WIDTH-1:0] bias_in,
    input  logic                         bias_wen,
    input  logic [$clog2(M)-1:0]         bias_addr,
    neural_layer_stream_if.slave         bus,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   sat_count
);
    localparam int AW = $clog2(M);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(M-1);

    localparam logic [1:0] ACT_RELU   = 2'b00;
    localparam logic [1:0] ACT_LEAKY  = 2'b01;
    localparam logic [1:0] ACT_LINEAR = 2'b10;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH-1:0] CLIP_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] CLIP_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                        state, state_nxt;
    logic [1:0]                    act_q;
    logic [AW-1:0]                 neuron_idx;
    logic signed [DATA_WIDTH-1:0]  bias_mem [M];
    logic signed [DATA_WIDTH-1:0]  bias_cur;
    logic                          addr_ok;
    logic                          accept, push, pop;

    logic [ACC_WIDTH:0]            sum_wide;
    logic                          s1_ovf;
    logic signed [ACC_WIDTH-1:0]   sum_sat;
    logic                          s1_valid, s1_last;
    logic signed [ACC_WIDTH-1:0]   s1_data;
    logic signed [ACC_WIDTH-1:0]   act_out;
    logic                          s2_valid, s2_last;
    logic signed [ACC_WIDTH-1:0]   s2_data;

    logic [ACC_WIDTH:0]            fifo_mem [FIFO_DEPTH];
    logic [ACC_WIDTH:0]            fifo_head;
    logic [FW-1:0]                 wr_ptr, rd_ptr;
    logic [FW:0]                   fifo_count;
    logic [FW+1:0]                 fill;

    // Counting in-flight stage entries guarantees space in the FIFO for
    // every beat we accept, so the push side never needs a full check.
    assign fill         = (FW+2)'(fifo_count) + (FW+2)'(s1_valid) + (FW+2)'(s2_valid);
    assign bus.in_ready = (state == S_RUN) && (fill < (FW+2)'(FIFO_DEPTH));
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = s2_valid;
    assign pop          = bus.out_valid && bus.out_ready;

    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (accept && (neuron_idx == LAST_IDX)) state_nxt = S_DRAIN;
            S_DRAIN: if (pop && bus.out_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            act_q      <= '0;
            neuron_idx <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && start) begin
                act_q      <= activation_type;
                neuron_idx <= '0;
            end else if (accept) begin
                neuron_idx <= neuron_idx + 1'b1;
            end
        end
    end

    generate
        if ((1 << AW) == M) begin : g_addr_full
            assign addr_ok = 1'b1;
        end else begin : g_addr_chk
            assign addr_ok = ({1'b0, bias_addr} < (AW+1)'(M));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++) bias_mem[i] <= '0;
        end else if (bias_wen && (state == S_IDLE) && addr_ok) begin
            bias_mem[bias_addr] <= bias_in;
        end
    end

    // Stage 1: one extra bit of headroom; overflow shows as the top two bits disagreeing.
    assign bias_cur = bias_mem[neuron_idx];
    assign sum_wide = {bus.in_data[ACC_WIDTH-1], bus.in_data}
                    + {{(ACC_WIDTH+1-DATA_WIDTH){bias_cur[DATA_WIDTH-1]}}, bias_cur};
    assign s1_ovf   = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    assign sum_sat  = !s1_ovf ? sum_wide[ACC_WIDTH-1:0]
                    : (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX);

    always_comb begin
        act_out = s1_data;
        case (act_q)
            ACT_RELU:   if (s1_data[ACC_WIDTH-1]) act_out = '0;
            ACT_LEAKY:  if (s1_data[ACC_WIDTH-1]) act_out = s1_data >>> LEAK_SHIFT;
            ACT_LINEAR: act_out = s1_data;
            default: begin
                if (s1_data > CLIP_MAX)      act_out = CLIP_MAX;
                else if (s1_data < CLIP_MIN) act_out = CLIP_MIN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= sum_sat;
                s1_last <= (neuron_idx == LAST_IDX);
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= act_out;
                s2_last <= s1_last;
            end
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {s2_last, s2_data};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign fifo_head     = fifo_mem[rd_ptr];
    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_data  = bus.out_valid ? fifo_head[ACC_WIDTH-1:0] : '0;
    assign bus.out_last  = bus.out_valid && fifo_head[ACC_WIDTH];

`ifdef NEURAL_SAT_COUNT_EN
    logic       sat_ev, clamp_ev;
    logic [8:0] sat_sum;
    logic [7:0] sat_cnt_q;

    assign sat_ev   = accept && s1_ovf;
    assign clamp_ev = s1_valid && (act_q == 2'b11)
                   && ((s1_data > CLIP_MAX) || (s1_data < CLIP_MIN));
    assign sat_sum  = {1'b0, sat_cnt_q} + {8'd0, sat_ev} + {8'd0, clamp_ev};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sat_cnt_q <= '0;
        else     sat_cnt_q <= sat_sum[8] ? 8'hff : sat_sum[7:0];
    end

    assign sat_count = sat_cnt_q;
`else
    assign sat_count = 8'd0;
`endif

endmodule

// File: tb/tb_neural_layer_stream.sv
// ---------------------------------------------------------------------------
// tb_neural_layer_stream
//   Directed bench for neural_layer_stream. dut4 (M=4) covers the activation
//   modes, saturation, bias gating and reset abort; dut8 (M=8, depth 4)
//   covers output backpressure. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_neural_layer_stream;

`ifdef NEURAL_SAT_COUNT_EN
    localparam int SAT_INC = 1;
`else
    localparam int SAT_INC = 0;
`endif

    logic        clk;
    logic        rst;

    logic        start;
    logic [1:0]  activation_type;
    logic [7:0]  bias_in;
    logic        bias_wen;
    logic [1:0]  bias_addr;
    logic        busy, done;
    logic [7:0]  sat_count;

    logic        start8;
    logic [1:0]  act8;
    logic [7:0]  bias_in8;
    logic        bias_wen8;
    logic [2:0]  bias_addr8;
    logic        busy8, done8;
    logic [7:0]  sat8;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt4 = 0;
    int vin[4];
    int vexp[4];

    neural_layer_stream_if #(.ACC_WIDTH(16)) bus4 ();
    neural_layer_stream_if #(.ACC_WIDTH(16)) bus8 ();

    neural_layer_stream #(
        .M(4), .DATA_WIDTH(8), .ACC_WIDTH(16), .LEAK_SHIFT(3), .FIFO_DEPTH(4)
    ) dut4 (
        .clk(clk), .rst(rst), .start(start), .activation_type(activation_type),
        .bias_in(bias_in), .bias_wen(bias_wen), .bias_addr(bias_addr),
        .bus(bus4), .busy(busy), .done(done), .sat_count(sat_count)
    );

    neural_layer_stream #(
        .M(8), .DATA_WIDTH(8), .ACC_WIDTH(16), .LEAK_SHIFT(3), .FIFO_DEPTH(4)
    ) dut8 (
        .clk(clk), .rst(rst), .start(start8), .activation_type(act8),
        .bias_in(bias_in8), .bias_wen(bias_wen8), .bias_addr(bias_addr8),
        .bus(bus8), .busy(busy8), .done(done8), .sat_count(sat8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        done_cnt4 <= done_cnt4 + (done ? 1 : 0);
    end

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr_bias(input int a, input int v);
        bias_wen  = 1'b1;
        bias_addr = a[1:0];
        bias_in   = v[7:0];
        @(negedge clk);
        bias_wen  = 1'b0;
    endtask

    // Runs one vector on dut4 from vin[], checking against vexp[]. Starts on
    // the current negedge so consecutive calls exercise back-to-back starts.
    task automatic run_vec4(input string tag, input logic [1:0] act);
        int acc_cyc[4];
        int n_acc = 0;
        int n_out = 0;
        int guard = 0;
        int d0;
        start           = 1'b1;
        activation_type = act;
        @(negedge clk);
        start           = 1'b0;
        activation_type = ~act;
        chk($sformatf("%s_busy", tag), busy, 1);
        chk($sformatf("%s_in_ready", tag), bus4.in_ready, 1);
        d0 = done_cnt4;
        bias_wen  = 1'b1;
        bias_addr = 2'd1;
        bias_in   = 8'h9d;
        while ((n_out < 4) && (guard < 50)) begin
            if (n_acc < 4) begin
                bus4.in_valid = 1'b1;
                bus4.in_data  = 16'(vin[n_acc]);
            end else begin
                bus4.in_valid = 1'b0;
            end
            if (bus4.in_valid && bus4.in_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            if (bus4.out_valid) begin
                chk($sformatf("%s_d%0d", tag, n_out), $signed(bus4.out_data), vexp[n_out]);
                chk($sformatf("%s_last%0d", tag, n_out), bus4.out_last, (n_out == 3) ? 1 : 0);
                chk($sformatf("%s_lat%0d", tag, n_out), cyc - acc_cyc[n_out], 3);
                n_out++;
            end
            @(negedge clk);
            bias_wen = 1'b0;
            guard++;
        end
        bus4.in_valid = 1'b0;
        chk($sformatf("%s_nres", tag), n_out, 4);
        chk($sformatf("%s_done", tag), done, 1);
        @(negedge clk);
        chk($sformatf("%s_done_off", tag), done, 0);
        chk($sformatf("%s_idle", tag), busy, 0);
        chk($sformatf("%s_done_pulses", tag), done_cnt4 - d0, 1);
    endtask

    initial begin
        int n_acc;
        int n_out;
        int guard;
        int d0;

        rst             = 1'b1;
        start           = 1'b0;
        activation_type = 2'b00;
        bias_in         = '0;
        bias_wen        = 1'b0;
        bias_addr       = '0;
        start8          = 1'b0;
        act8            = 2'b00;
        bias_in8        = '0;
        bias_wen8       = 1'b0;
        bias_addr8      = '0;
        bus4.in_data    = '0;
        bus4.in_valid   = 1'b0;
        bus4.out_ready  = 1'b1;
        bus8.in_data    = '0;
        bus8.in_valid   = 1'b0;
        bus8.out_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_in_ready",  bus4.in_ready, 0);
        chk("rst_out_valid", bus4.out_valid, 0);
        chk("rst_out_data",  $signed(bus4.out_data), 0);
        chk("rst_out_last",  bus4.out_last, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_done",      done, 0);
        chk("rst_sat",       sat_count, 0);

        // ReLU with mixed biases
        wr_bias(0, 0); wr_bias(1, 60); wr_bias(2, -10); wr_bias(3, 2);
        vin = '{100, -50, 300, -1};  vexp = '{100, 10, 290, 1};
        run_vec4("relu", 2'b00);

        // Leaky ReLU then linear, back to back
        wr_bias(0, 0); wr_bias(1, 0); wr_bias(2, 0); wr_bias(3, 0);
        vin = '{-64, 64, -1, -7};    vexp = '{-8, 64, -1, -1};
        run_vec4("leaky", 2'b01);
        vin = '{-64, 5, -300, 0};    vexp = '{-64, 5, -300, 0};
        run_vec4("linear", 2'b10);

        // Stage-1 saturation at both rails
        wr_bias(0, 127); wr_bias(1, -128);
        vin = '{32767, -32768, 0, 0}; vexp = '{32767, 0, 0, 0};
        run_vec4("sat", 2'b00);
        chk("sat_count_sat", sat_count, 2*SAT_INC);

        // Clip mode
        wr_bias(0, 0); wr_bias(1, 0);
        vin = '{300, -300, 5, 0};    vexp = '{127, -128, 5, 0};
        run_vec4("clip", 2'b11);
        chk("sat_count_clip", sat_count, 4*SAT_INC);

        // Backpressure on dut8
        start8 = 1'b1;
        act8   = 2'b10;
        @(negedge clk);
        start8 = 1'b0;
        n_acc  = 0;
        for (int i = 0; i < 10; i++) begin
            bus8.in_valid = 1'b1;
            bus8.in_data  = 16'(10*(n_acc+1));
            if (bus8.in_ready) n_acc++;
            @(negedge clk);
        end
        chk("bp_accepted", n_acc, 4);
        chk("bp_in_ready", bus8.in_ready, 0);
        chk("bp_out_valid", bus8.out_valid, 1);
        bus8.out_ready = 1'b1;
        n_out = 0;
        guard = 0;
        while ((n_out < 8) && (guard < 60)) begin
            if (n_acc < 8) begin
                bus8.in_valid = 1'b1;
                bus8.in_data  = 16'(10*(n_acc+1));
            end else begin
                bus8.in_valid = 1'b0;
            end
            if (bus8.in_valid && bus8.in_ready) n_acc++;
            if (bus8.out_valid) begin
                chk($sformatf("bp_d%0d", n_out), $signed(bus8.out_data), 10*(n_out+1));
                chk($sformatf("bp_last%0d", n_out), bus8.out_last, (n_out == 7) ? 1 : 0);
                n_out++;
            end
            @(negedge clk);
            guard++;
        end
        bus8.in_valid = 1'b0;
        chk("bp_nres", n_out, 8);
        chk("bp_done", done8, 1);
        @(negedge clk);
        chk("bp_drained", bus8.out_valid, 0);
        chk("bp_idle", busy8, 0);
        chk("bp_sat", sat8, 0);

        // Reset mid-vector
        wr_bias(0, 5); wr_bias(1, 5); wr_bias(2, 5); wr_bias(3, 5);
        d0              = done_cnt4;
        start           = 1'b1;
        activation_type = 2'b00;
        @(negedge clk);
        start         = 1'b0;
        bus4.in_valid = 1'b1;
        bus4.in_data  = 16'd7;
        @(negedge clk);
        bus4.in_data  = 16'd8;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_out_valid", bus4.out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", bus4.in_ready, 0);
        rst = 1'b0;
        guard = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus4.out_valid) guard++;
        end
        chk("abort_no_output", guard, 0);
        chk("abort_no_done", done_cnt4 - d0, 0);
        chk("abort_sat_clear", sat_count, 0);
        vin = '{1, 2, 3, 4};  vexp = '{1, 2, 3, 4};
        run_vec4("post_rst", 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
